// File: rtl/spi_px_master.sv
// spi_px_master: SPI mode-0 pixel master, one word per CS frame; define SPI_PX_MASTER_BURST_EN to chain words under one CS
module spi_px_master #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_GAP    = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 rx_valid_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 busy_o,
  output logic                 spi_sck_o,
  output logic                 spi_cs_o,
  output logic                 spi_sdo_o,
  input  logic                 spi_sdi_i
);
  localparam int M1 = CLK_DIV > CS_SETUP ? CLK_DIV : CS_SETUP;
  localparam int M2 = CS_HOLD > CS_GAP ? CS_HOLD : CS_GAP;
  localparam int TMAX = M1 > M2 ? M1 : M2;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
`ifdef SPI_PX_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n, tmr_dec;
  logic [BW-1:0] bit_cnt, bit_n;
  logic hi, hi_n;
  logic [DATA_BITS-1:0] tx_sr, tx_sr_n, rx_sr, rx_sr_n, rx_data_n;
  logic sck_n, cs_n, sdo_n, ready_n, rx_valid_n;
  logic hs, t0;
  assign hs = tx_valid_i & tx_ready_o;
  assign t0 = tmr == '0;
  assign tmr_dec = tmr - TW'(1);
  assign busy_o = state != IDLE;
  // state register
  always_ff @(posedge clk_i)
    if (reset_i) state <= IDLE;
    else state <= state_n;
  // next-state: each timed state ends when its down-counter reaches zero
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = hs ? SETUP : IDLE;
      SETUP:   state_n = t0 ? SHIFT : SETUP;
      SHIFT:   state_n = (t0 && !hi && bit_cnt == '0) ? HOLD : SHIFT;
      HOLD:    state_n = t0 ? (hs ? SETUP : GAP) : HOLD;
      GAP:     state_n = t0 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // next values of the timer, shift registers and the registered outputs
  always_comb begin
    tmr_n = t0 ? tmr : tmr_dec;
    bit_n = bit_cnt;
    hi_n = hi;
    tx_sr_n = tx_sr;
    rx_sr_n = rx_sr;
    rx_data_n = rx_data_o;
    rx_valid_n = 1'b0;
    sck_n = spi_sck_o;
    cs_n = spi_cs_o;
    sdo_n = spi_sdo_o;
    case (state)
      IDLE: begin
        cs_n = ~hs;
        sck_n = 1'b0;
        sdo_n = hs & tx_data_i[DATA_BITS-1];
        tx_sr_n = hs ? tx_data_i : tx_sr;
        tmr_n = hs ? TW'(CS_SETUP - 1) : tmr;
      end
      SETUP: if (t0) begin
        sck_n = 1'b1;
        hi_n = 1'b1;
        tmr_n = TW'(CLK_DIV - 1);
        bit_n = BW'(DATA_BITS - 1);
      end
      SHIFT: if (t0 && hi) begin
        sck_n = 1'b0;
        hi_n = 1'b0;
        tmr_n = TW'(CLK_DIV - 1);
        rx_sr_n = {rx_sr[DATA_BITS-2:0], spi_sdi_i};
        tx_sr_n = {tx_sr[DATA_BITS-2:0], 1'b0};
        sdo_n = tx_sr[DATA_BITS-2];
      end else if (t0) begin
        sck_n = bit_cnt != '0;
        hi_n = bit_cnt != '0;
        tmr_n = bit_cnt == '0 ? TW'(CS_HOLD - 1) : TW'(CLK_DIV - 1);
        bit_n = bit_cnt == '0 ? bit_cnt : bit_cnt - BW'(1);
      end
      HOLD: if (t0) begin
        rx_valid_n = 1'b1;
        rx_data_n = rx_sr;
        cs_n = ~hs;
        sdo_n = hs & tx_data_i[DATA_BITS-1];
        tx_sr_n = hs ? tx_data_i : tx_sr;
        tmr_n = hs ? TW'(CS_SETUP - 1) : TW'(CS_GAP - 1);
      end
      GAP: begin
        cs_n = 1'b1;
        sdo_n = 1'b0;
      end
      default: cs_n = 1'b1;
    endcase
    ready_n = state_n == IDLE || (BURST && state_n == HOLD && tmr_n == '0);
  end
  // datapath and registered outputs; reset drops CS and SCK immediately
  always_ff @(posedge clk_i)
    if (reset_i) begin
      tmr <= '0;
      bit_cnt <= '0;
      hi <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      spi_sck_o <= 1'b0;
      spi_cs_o <= 1'b1;
      spi_sdo_o <= 1'b0;
    end else begin
      tmr <= tmr_n;
      bit_cnt <= bit_n;
      hi <= hi_n;
      tx_sr <= tx_sr_n;
      rx_sr <= rx_sr_n;
      rx_data_o <= rx_data_n;
      rx_valid_o <= rx_valid_n;
      tx_ready_o <= ready_n;
      spi_sck_o <= sck_n;
      spi_cs_o <= cs_n;
      spi_sdo_o <= sdo_n;
    end
endmodule

// File: tb/tb_spi_px_master.sv
// tb_spi_px_master: random pixel traffic against an SPI slave model and a latency/data scoreboard
module tb_spi_px_master;
  localparam int W = 8;
  localparam int LAT = 69;
  localparam int CSLOW = 68;
`ifdef SPI_PX_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
  localparam int B2B = 68;
`else
  localparam bit BURST = 1'b0;
  localparam int B2B = 73;
`endif
  logic clk = 1'b0, reset = 1'b1, tx_valid = 1'b0, sdi = 1'b0;
  logic tx_ready, rx_valid, busy, sck, cs, sdo;
  logic [W-1:0] tx_data = '0, rx_data, next_resp = '0;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_rx[$], exp_mosi[$], resp_q[$];
  int exp_cyc[$];
  int sbit = 0, cs_low = 0, cs_high = 100, cs_rises = 0, last_hs = 0;
  logic [W-1:0] mcap = '0;
  bit psck = 1'b0, rdy_bad = 1'b0, chk_gap = 1'b0, gap_armed = 1'b0;

  spi_px_master dut (
    .clk_i(clk), .reset_i(reset), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_data_i(tx_data), .rx_valid_o(rx_valid), .rx_data_o(rx_data), .busy_o(busy),
    .spi_sck_o(sck), .spi_cs_o(cs), .spi_sdo_o(sdo), .spi_sdi_i(sdi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // observer: handshakes feed the scoreboard, rx pulses are popped and compared, slave model drives MISO
  always @(negedge clk) begin
    if (reset) begin
      exp_rx.delete(); exp_cyc.delete(); exp_mosi.delete(); resp_q.delete();
      sbit = 0; cs_low = 0; cs_high = 100; psck = 1'b0; rdy_bad = 1'b0; gap_armed = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        exp_mosi.push_back(tx_data);
        exp_rx.push_back(next_resp);
        resp_q.push_back(next_resp);
        exp_cyc.push_back(cyc + LAT);
        if (chk_gap && gap_armed) chk("b2b_handshake_gap", cyc - last_hs, B2B);
        gap_armed = chk_gap;
        last_hs = cyc;
      end else if (busy && tx_ready && !(BURST && cyc - last_hs == CSLOW)) rdy_bad = 1'b1;
      if (rx_valid) begin
        chk("ready_low_in_frame", int'(rdy_bad), 0);
        rdy_bad = 1'b0;
        if (exp_rx.size() == 0) chk("unexpected_rx", 1, 0);
        else begin
          chk("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
          chk("rx_cycle", cyc, exp_cyc.pop_front());
        end
      end
      if (sck && !psck) mcap = {mcap[W-2:0], sdo};
      if (!sck && psck) begin
        sbit++;
        if (sbit == W) begin
          sbit = 0;
          if (exp_mosi.size() == 0) chk("stray_mosi_word", 1, 0);
          else chk("mosi_word", int'(mcap), int'(exp_mosi.pop_front()));
          if (resp_q.size() > 0) void'(resp_q.pop_front());
        end
      end
      psck = sck;
      if (!cs) begin
        if (cs_low == 0) chk("cs_gap_min", int'(cs_high >= 4), 1);
        cs_low++;
        cs_high = 0;
      end else begin
        if (cs_low > 0) begin
          cs_rises++;
          if (!BURST) chk("cs_low_len", cs_low, CSLOW);
        end
        cs_low = 0;
        if (cs_high < 100) cs_high++;
      end
    end
    sdi = (resp_q.size() > 0) ? resp_q[0][W-1-sbit] : 1'b0;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      tx_valid = 1'b0;
      tx_data = W'($urandom);
    end
  endtask

  task automatic send(input logic [W-1:0] w, input logic [W-1:0] r, input bit keep);
    int t = 0;
    tx_valid = 1'b1; tx_data = w; next_resp = r;
    do begin @(negedge clk); t++; end while (!tx_ready && t < 300);
    if (t >= 300) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    tx_valid = keep;
    tx_data = W'($urandom);
  endtask

  initial begin
    int r0;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_cs", int'(cs), 1);
    chk("reset_sck", int'(sck), 0);
    chk("reset_sdo", int'(sdo), 0);
    chk("reset_ready", int'(tx_ready), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("ready_after_reset", int'(tx_ready), 1);
    @(posedge clk); #1;
    send(8'hA5, 8'h3C, 1'b0);
    idle(80);
    chk_gap = 1'b1;
    send(8'h00, 8'hFF, 1'b1);
    send(8'hFF, 8'h00, 1'b0);
    chk_gap = 1'b0;
    idle(80);
    send(8'hC3, 8'h96, 1'b0);
    repeat (29) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_cs", int'(cs), 1);
    chk("midreset_sck", int'(sck), 0);
    chk("midreset_rx_valid", int'(rx_valid), 0);
    @(negedge clk);
    chk("midreset_ready", int'(tx_ready), 1);
    @(posedge clk); #1;
    send(8'h5A, W'($urandom), 1'b0);
    idle(80);
    for (int i = 0; i < 12; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      idle($urandom_range(0, 5));
    end
    idle(160);
    begin
      int base;
      base = cs_rises;
      send(8'h11, W'($urandom), 1'b1);
      send(8'h22, W'($urandom), 1'b1);
      send(8'h33, W'($urandom), 1'b0);
      idle(90);
      chk("cs_frames_for_three_words", cs_rises - base, BURST ? 1 : 3);
    end
    idle(20);
    chk("pending_rx", exp_rx.size(), 0);
    chk("pending_mosi", exp_mosi.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
